sdram_init_seq: RTL and testbench

Parametrised SDRAM power-up initialisation sequencer. It replaces the fixed-count init block with a timing-driven state machine. Power-up wait, tRP, tRFC, tMRD, the auto-refresh count, address width and mode register value are all parameters. It also adds a re-initialisation request. It sits between the PHY-facing command/address mux and the arbiter, and drives the bus until flag_init_end rises.

---
 rtl/sdram_init_seq.sv | 189 ++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up initialisation sequencer.
// Issues PRECHARGE-all, AREF_NUM auto-refreshes and a mode-register set,
// each spaced by its timing parameter. It then raises flag_init_end.
// A re-init request accepted in DONE restarts the sequence without the
// power-up wait.
// Optional feature macro: SDRAM_INIT_EMRS_EN. When it is defined, an extended
// mode-register set (ba=2'b10, addr=EMODE_VAL) follows the mode-register set.
module sdram_init_seq #(
  parameter int          ADDR_W    = 13,
  parameter int          T_POWERUP = 10000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 7,
  parameter int          T_MRD     = 3,
  parameter int          AREF_NUM  = 2,
  parameter logic [12:0] MODE_VAL  = 13'h032,
  parameter logic [12:0] EMODE_VAL = 13'h000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_req,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              init_busy,
  output logic              flag_init_end
);

`ifdef SDRAM_INIT_EMRS_EN
  localparam bit EMRS_EN = 1'b1;
`else
  localparam bit EMRS_EN = 1'b0;
`endif

  // One shared cycle counter, sized for the longest interval it ever holds.
  localparam int MAX_A = (T_POWERUP > T_RP) ? T_POWERUP : T_RP;
  localparam int MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam int AREF_W = $clog2(AREF_NUM + 1);

  localparam logic [CNT_W-1:0]  PWR_C    = CNT_W'(T_POWERUP);
  localparam logic [CNT_W-1:0]  RP_C     = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0]  RFC_C    = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0]  MRD_C    = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [AREF_W-1:0] AREF_C   = AREF_W'(AREF_NUM);
  localparam logic [AREF_W-1:0] AREF_ONE = AREF_W'(1);

  localparam logic [ADDR_W-1:0] PRE_ADDR   = ADDR_W'(32'h400);
  localparam logic [ADDR_W-1:0] MODE_ADDR  = ADDR_W'(MODE_VAL);
  localparam logic [ADDR_W-1:0] EMODE_ADDR = ADDR_W'(EMODE_VAL);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  // A command state (PRE, AREF, MRS, EMRS) is the cycle its command is on the
  // bus. The matching WAIT_* state covers the remaining cycles of its interval.
  typedef enum logic [3:0] {
    WAIT_PWR, PRE, WAIT_RP, AREF, WAIT_RFC, MRS, WAIT_MRD, EMRS, WAIT_EMRD, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [AREF_W-1:0]   aref_reg, aref_next;
  logic [3:0]          cmd_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [1:0]          ba_next;
  logic                busy_next, flag_next;

  // State, counters and all bus outputs are registered together.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= WAIT_PWR;
      cnt_reg       <= '0;
      aref_reg      <= '0;
      cmd_reg       <= CMD_NOP;
      sdram_addr    <= '0;
      sdram_ba      <= '0;
      init_busy     <= 1'b1;
      flag_init_end <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      aref_reg      <= aref_next;
      cmd_reg       <= cmd_next;
      sdram_addr    <= addr_next;
      sdram_ba      <= ba_next;
      init_busy     <= busy_next;
      flag_init_end <= flag_next;
    end
  end

  // Next state and next outputs. The counter holds the number of edges since the
  // last command, so the next command is issued when it reaches T_x.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    aref_next  = aref_reg;
    cmd_next   = CMD_NOP;
    addr_next  = '0;
    ba_next    = '0;
    busy_next  = init_busy;
    flag_next  = flag_init_end;
    case (state_reg)
      // In WAIT_PWR the counter is 0 at edge 1, so PRECHARGE is issued at edge T_POWERUP+1.
      WAIT_PWR: begin
        if (cnt_reg == PWR_C) begin
          state_next = PRE;
          cmd_next   = CMD_PRE;
          addr_next  = PRE_ADDR;
          cnt_next   = CNT_ONE;
          aref_next  = '0;
        end
      end
      PRE, WAIT_RP: begin
        if (cnt_reg == RP_C) begin
          state_next = AREF;
          cmd_next   = CMD_AREF;
          cnt_next   = CNT_ONE;
          aref_next  = aref_reg + AREF_ONE;
        end else begin
          state_next = WAIT_RP;
        end
      end
      AREF, WAIT_RFC: begin
        if (cnt_reg == RFC_C) begin
          cnt_next = CNT_ONE;
          if (aref_reg == AREF_C) begin
            state_next = MRS;
            cmd_next   = CMD_MRS;
            addr_next  = MODE_ADDR;
          end else begin
            state_next = AREF;
            cmd_next   = CMD_AREF;
            aref_next  = aref_reg + AREF_ONE;
          end
        end else begin
          state_next = WAIT_RFC;
        end
      end
      MRS, WAIT_MRD: begin
        if (cnt_reg == MRD_C) begin
          if (EMRS_EN) begin
            state_next = EMRS;
            cmd_next   = CMD_MRS;
            addr_next  = EMODE_ADDR;
            ba_next    = 2'b10;
            cnt_next   = CNT_ONE;
          end else begin
            state_next = DONE;
            busy_next  = 1'b0;
            flag_next  = 1'b1;
            cnt_next   = '0;
          end
        end else begin
          state_next = WAIT_MRD;
        end
      end
      EMRS, WAIT_EMRD: begin
        if (cnt_reg == MRD_C) begin
          state_next = DONE;
          busy_next  = 1'b0;
          flag_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          state_next = WAIT_EMRD;
        end
      end
      // A re-init preloads the counter with the expiry value, so PRECHARGE
      // follows on the very next edge.
      DONE: begin
        cnt_next = cnt_reg;
        if (init_req) begin
          state_next = WAIT_PWR;
          cnt_next   = PWR_C;
          busy_next  = 1'b1;
          flag_next  = 1'b0;
        end
      end
      default: begin
        state_next = WAIT_PWR;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: directed edge-by-edge check of two sequencer instances.
// Instance A uses the main timing set and instance B uses the minimum timings.
// Every edge is compared with a hand-computed event table.
module tb_sdram_init_seq;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [3:0]  cmd_a, cmd_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        busy_a, busy_b, end_a, end_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_init_seq #(
    .ADDR_W(13), .T_POWERUP(20), .T_RP(2), .T_RFC(4), .T_MRD(2), .AREF_NUM(3),
    .MODE_VAL(13'h032), .EMODE_VAL(13'h005)
  ) dut_a (
    .sys_clk(clk), .sys_rst(rst), .init_req(req_a),
    .cmd_reg(cmd_a), .sdram_addr(addr_a), .sdram_ba(ba_a),
    .init_busy(busy_a), .flag_init_end(end_a)
  );

  sdram_init_seq #(
    .ADDR_W(13), .T_POWERUP(20), .T_RP(1), .T_RFC(1), .T_MRD(1), .AREF_NUM(1),
    .MODE_VAL(13'h032), .EMODE_VAL(13'h005)
  ) dut_b (
    .sys_clk(clk), .sys_rst(rst), .init_req(req_b),
    .cmd_reg(cmd_b), .sdram_addr(addr_b), .sdram_ba(ba_b),
    .init_busy(busy_b), .flag_init_end(end_b)
  );

  // Hand-computed edges of each command and of completion (-1 = none).
  typedef struct {
    int pre;
    int aref0;
    int aref1;
    int aref2;
    int mrs;
    int emrs;
    int done;
  } tl_t;

`ifdef SDRAM_INIT_EMRS_EN
  localparam tl_t TL_A1 = '{21, 23, 27, 31, 35, 37, 39};
  localparam tl_t TL_A2 = '{41, 43, 47, 51, 55, 57, 59};
  localparam tl_t TL_B  = '{21, 22, -1, -1, 23, 24, 25};
`else
  localparam tl_t TL_A1 = '{21, 23, 27, 31, 35, -1, 37};
  localparam tl_t TL_A2 = '{41, 43, 47, 51, 55, -1, 57};
  localparam tl_t TL_B  = '{21, 22, -1, -1, 23, -1, 24};
`endif

  localparam logic [20:0] RST_VEC = {NOP, 13'h000, 2'b00, 1'b1, 1'b0};

  // Expected bus {cmd, addr, ba, busy, flag} at edge k of a timeline.
  function automatic logic [20:0] exp_vec(int k, tl_t t);
    logic [3:0]  c;
    logic [12:0] a;
    logic [1:0]  b;
    logic        busy;
    logic        flag;
    c = NOP; a = 13'h000; b = 2'b00; busy = 1'b1; flag = 1'b0;
    if (k == t.pre) begin c = PRE; a = 13'h400; end
    if (k == t.aref0 || k == t.aref1 || k == t.aref2) c = AREF;
    if (k == t.mrs) begin c = MRS; a = 13'h032; end
    if (k == t.emrs) begin c = MRS; a = 13'h005; b = 2'b10; end
    if (k >= t.done) begin busy = 1'b0; flag = 1'b1; end
    return {c, a, b, busy, flag};
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Steps edges first..last starting from a negedge. init_req on A is pulsed
  // for the edge numbered req_edge. Both instances are checked 1 ns after each edge.
  task automatic run_edges(input int first, input int last, input tl_t ta, input int req_edge);
    for (int k = first; k <= last; k++) begin
      req_a = (k == req_edge);
      @(posedge clk);
      #1;
      $display("edge %0d: A cmd=%b addr=%h ba=%b busy=%b end=%b | B cmd=%b addr=%h busy=%b end=%b",
               k, cmd_a, addr_a, ba_a, busy_a, end_a, cmd_b, addr_b, busy_b, end_b);
      check($sformatf("A_edge%0d", k), {cmd_a, addr_a, ba_a, busy_a, end_a}, exp_vec(k, ta));
      check($sformatf("B_edge%0d", k), {cmd_b, addr_b, ba_b, busy_b, end_b}, exp_vec(k, TL_B));
      @(negedge clk);
    end
    req_a = 1'b0;
  endtask

  initial begin
    // Power-on reset held across two edges.
    repeat (2) @(posedge clk);
    #1;
    check("A_reset", {cmd_a, addr_a, ba_a, busy_a, end_a}, RST_VEC);
    check("B_reset", {cmd_b, addr_b, ba_b, busy_b, end_b}, RST_VEC);
    @(negedge clk);
    rst = 1'b0;

    // Clean sequence, then a re-init request accepted at edge 40.
    run_edges(1, 39, TL_A1, -1);
    run_edges(40, 60, TL_A2, 40);

    // Asynchronous reset while in DONE clears outputs without a clock edge.
    rst = 1'b1;
    #1;
    check("A_async_rst_done", {cmd_a, addr_a, ba_a, busy_a, end_a}, RST_VEC);
    check("B_async_rst_done", {cmd_b, addr_b, ba_b, busy_b, end_b}, RST_VEC);
    @(posedge clk);
    #1;
    check("A_rst_held", {cmd_a, addr_a, ba_a, busy_a, end_a}, RST_VEC);
    @(negedge clk);
    rst = 1'b0;

    // init_req during the power-up wait is ignored. Reset is pulsed across
    // edge 28, while the AREF from edge 27 is still on the bus.
    run_edges(1, 27, TL_A1, 10);
    rst = 1'b1;
    #1;
    check("A_async_rst_mid", {cmd_a, addr_a, ba_a, busy_a, end_a}, RST_VEC);
    @(posedge clk);
    #1;
    check("A_rst_edge28", {cmd_a, addr_a, ba_a, busy_a, end_a}, RST_VEC);
    @(negedge clk);
    rst = 1'b0;

    // After a mid-sequence reset, the full sequence restarts from the power-up wait.
    run_edges(1, 40, TL_A1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
